reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/regfile_pkg.sv | 18 +
 rtl/reg_write_arbiter_rr_arbiter2.sv | 38 +++
 rtl/reg_write_arbiter.sv | 126 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback source identifiers used by
// the register file and its write-port arbiter.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef enum logic {
        SRC_ALU  = 1'b0,
        SRC_LOAD = 1'b1
    } src_id_e;

    function automatic src_id_e otherSrc(input src_id_e s);
        return (s == SRC_ALU) ? SRC_LOAD : SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter (module rr_arbiter2). The pointer names the
// preferred requester and moves to the other one after every grant.
import regfile_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output src_id_e    ptr
);

    src_id_e ptrNext;

    always_comb begin
        grant   = 2'b00;
        ptrNext = ptr;
        if (req == 2'b11) begin
            grant = (ptr == SRC_ALU) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
        if (grant[0]) begin
            ptrNext = otherSrc(SRC_ALU);
        end else if (grant[1]) begin
            ptrNext = otherSrc(SRC_LOAD);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= SRC_ALU;
        end else begin
            ptr <= ptrNext;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: one holding slot per writeback source, a
// round-robin grant per cycle, and an optional pending-write scoreboard
// (enabled by defining REG_WRITE_ARBITER_SCOREBOARD_EN).
import regfile_pkg::*;

module reg_write_arbiter #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s0_valid,
    output logic                     s0_ready,
    input  logic [$clog2(NREG)-1:0]  s0_rd,
    input  logic [XLEN-1:0]          s0_data,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [$clog2(NREG)-1:0]  s1_rd,
    input  logic [XLEN-1:0]          s1_data,
    output logic                     wr_en,
    output logic [$clog2(NREG)-1:0]  wr_addr,
    output logic [XLEN-1:0]          wr_data,
    input  logic                     mark_valid,
    input  logic [$clog2(NREG)-1:0]  mark_rd,
    input  logic [$clog2(NREG)-1:0]  q_rs1,
    input  logic [$clog2(NREG)-1:0]  q_rs2,
    output logic                     busy1,
    output logic                     busy2
);

    localparam int AW = $clog2(NREG);

    // Handshake: a source transfers at the rising edge where sN_valid and
    // sN_ready are both high; ready is high when the slot is empty or is
    // being granted this cycle, so a draining slot refills without a bubble.

    logic            holdV0, holdV1;
    logic [AW-1:0]   holdRd0, holdRd1;
    logic [XLEN-1:0] holdD0, holdD1;
    logic [1:0]      grant;
    src_id_e         arbPtr;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({holdV1, holdV0}),
        .grant (grant),
        .ptr   (arbPtr)
    );

    assign s0_ready = !holdV0 || grant[0];
    assign s1_ready = !holdV1 || grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdV0  <= 1'b0;
            holdRd0 <= '0;
            holdD0  <= '0;
        end else if (s0_valid && s0_ready) begin
            holdV0  <= 1'b1;
            holdRd0 <= s0_rd;
            holdD0  <= s0_data;
        end else if (grant[0]) begin
            holdV0  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdV1  <= 1'b0;
            holdRd1 <= '0;
            holdD1  <= '0;
        end else if (s1_valid && s1_ready) begin
            holdV1  <= 1'b1;
            holdRd1 <= s1_rd;
            holdD1  <= s1_data;
        end else if (grant[1]) begin
            holdV1  <= 1'b0;
        end
    end

    // Port follows the granted slot; register 0 entries retire without a write.
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (grant[0]) begin
            wr_addr = holdRd0;
            wr_data = holdD0;
        end else if (grant[1]) begin
            wr_addr = holdRd1;
            wr_data = holdD1;
        end
    end

    assign wr_en = (|grant) && (wr_addr != '0);

`ifdef REG_WRITE_ARBITER_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic            unusedSink;

    // The set is applied last so a new reservation beats a same-edge commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_en) begin
                busy[wr_addr] <= 1'b0;
            end
            if (mark_valid && (mark_rd != '0)) begin
                busy[mark_rd] <= 1'b1;
            end
        end
    end

    assign busy1      = (q_rs1 != '0) && busy[q_rs1];
    assign busy2      = (q_rs2 != '0) && busy[q_rs2];
    assign unusedSink = ^{arbPtr};
`else
    logic unusedSink;

    assign busy1      = 1'b0;
    assign busy2      = 1'b0;
    assign unusedSink = ^{arbPtr, mark_valid, mark_rd, q_rs1, q_rs2};
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: drivers push expected register-file
// writes into a queue, a negedge monitor pops and compares each write.
module tb_reg_write_arbiter;

`ifdef REG_WRITE_ARBITER_SCOREBOARD_EN
    localparam logic SB_ON = 1'b1;
`else
    localparam logic SB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_rd = '0, s1_rd = '0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mark_valid = 1'b0;
    logic [4:0]  mark_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic        busy1, busy2;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int wrCount = 0;
    int firstCyc = 0;
    int lastCyc = 0;
    logic [36:0] exp_q[$];

    reg_write_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        mark_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- drivers (call at posedge+1) ----------------
    task automatic drive0(input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        s0_valid = 1'b1;
        s0_rd = rd;
        s0_data = d;
        @(negedge clk);
        while (!s0_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s0_handshake", s0_ready, 1);
        @(posedge clk);
        #1 s0_valid = 1'b0;
    endtask

    task automatic drive1(input logic [4:0] rd, input logic [31:0] d);
        int n = 0;
        s1_valid = 1'b1;
        s1_rd = rd;
        s1_data = d;
        @(negedge clk);
        while (!s1_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("s1_handshake", s1_ready, 1);
        @(posedge clk);
        #1 s1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        sync();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {wr_addr, wr_data}, 0);
            end else begin
                check("wr_port", {wr_addr, wr_data}, exp_q.pop_front());
            end
            if (wrCount == 0) firstCyc = cycle;
            lastCyc = cycle;
            wrCount++;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        apply_reset();
        @(negedge clk);
        check("reset_wr_en", wr_en, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_s0_ready", s0_ready, 1);
        check("reset_s1_ready", s1_ready, 1);
        check("reset_busy1", busy1, 0);
        sync();

        // Single uncontended write, one cycle to the write port.
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        drive0(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("single_wr_en", wr_en, 1);
        check("single_wr_addr", wr_addr, 5);
        check("single_s0_ready", s0_ready, 1);
        wait_drain();

        // Both sources streaming: alternate 1,2,... starting with source 0.
        apply_reset();
        wrCount = 0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({5'd1, 32'hA000_0000 + i});
            exp_q.push_back({5'd2, 32'hB000_0000 + i});
        end
        fork
            begin
                for (int i = 0; i < 6; i++) drive0(5'd1, 32'hA000_0000 + i);
            end
            begin
                for (int i = 0; i < 6; i++) drive1(5'd2, 32'hB000_0000 + i);
            end
        join
        wait_drain();
        check("stream_count", wrCount, 12);
        check("stream_no_gaps", lastCyc - firstCyc, 11);

        // Register 0 entry retires without a write and still moves the pointer.
        apply_reset();
        exp_q.push_back({5'd3, 32'h0000_0033});
        drive0(5'd3, 32'h0000_0033);
        drive1(5'd0, 32'h0000_1234);
        @(negedge clk);
        check("rd0_wr_en", wr_en, 0);
        check("rd0_wr_data", wr_data, 32'h1234);
        check("rd0_s1_ready", s1_ready, 1);
        sync();
        exp_q.push_back({5'd4, 32'h0000_0044});
        exp_q.push_back({5'd6, 32'h0000_0066});
        fork
            drive0(5'd4, 32'h0000_0044);
            drive1(5'd6, 32'h0000_0066);
        join
        wait_drain();

        // Scoreboard: reservation cleared by the commit, unless re-marked then.
        apply_reset();
        q_rs1 = 5'd7;
        q_rs2 = 5'd0;
        mark_valid = 1'b1;
        mark_rd = 5'd7;
        sync();
        mark_valid = 1'b0;
        @(negedge clk);
        check("sb_busy1_marked", busy1, SB_ON);
        check("sb_busy2_r0", busy2, 0);
        sync();
        exp_q.push_back({5'd7, 32'h0000_0777});
        drive1(5'd7, 32'h0000_0777);
        @(negedge clk);
        check("sb_busy1_before_commit", busy1, SB_ON);
        sync();
        @(negedge clk);
        check("sb_busy1_after_commit", busy1, 0);
        sync();
        mark_valid = 1'b1;
        mark_rd = 5'd7;
        sync();
        mark_valid = 1'b0;
        exp_q.push_back({5'd7, 32'h0000_0778});
        drive1(5'd7, 32'h0000_0778);
        mark_valid = 1'b1;
        mark_rd = 5'd7;
        sync();
        mark_valid = 1'b0;
        @(negedge clk);
        check("sb_set_beats_clear", busy1, SB_ON);
        wait_drain();

        // Reservation of register 3 visible only when the scoreboard is built.
        q_rs1 = 5'd3;
        q_rs2 = 5'd3;
        mark_valid = 1'b1;
        mark_rd = 5'd3;
        sync();
        mark_valid = 1'b0;
        @(negedge clk);
        check("sb_busy1_r3", busy1, SB_ON);
        check("sb_busy2_r3", busy2, SB_ON);
        sync();

        // Reset with both slots loaded discards them without a write.
        q_rs2 = 5'd9;
        s0_valid = 1'b1; s0_rd = 5'd10; s0_data = 32'h1010;
        s1_valid = 1'b1; s1_rd = 5'd11; s1_data = 32'h1111;
        mark_valid = 1'b1;
        mark_rd = 5'd9;
        @(posedge clk);
        #1;
        rst = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        mark_valid = 1'b0;
        @(negedge clk);
        check("midrst_wr_en", wr_en, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_s0_ready", s0_ready, 1);
        check("postrst_s1_ready", s1_ready, 1);
        check("postrst_busy2", busy2, 0);
        check("postrst_busy1", busy1, 0);
        check("postrst_wr_en", wr_en, 0);
        check("postrst_wr_addr", wr_addr, 0);
        repeat (3) @(negedge clk);
        check("postrst_idle_wr_en", wr_en, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
